mux_sel_arbiter: RTL and testbench

Two-requester arbiter that sits directly upstream of the 2:1 multiplexer and drives its select input `S`. It grants the shared datapath to source A or source B with round-robin fairness and a bounded hold time. Every output is registered, so `S` never glitches while the mux output `F` is being consumed. `S = 0` selects A and `S = 1` selects B, matching the mux convention `F = S ? B : A`.

---
 rtl/mux_sel_pkg.sv | 13 +
 rtl/sat_counter.sv | 33 +++
 rtl/mux_sel_arbiter.sv | 102 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and select encodings for the mux select arbiter.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } sel_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, load-to-one and enable.
module sat_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load1_i) begin
      cnt_q <= CNT_ONE;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin two-source arbiter driving the 2:1 mux select, with a bounded
// hold time and fully registered outputs so S never glitches.
//
//   state    | meaning
//   ST_IDLE  | no grant active; S keeps its last value
//   ST_GNT_A | source A owns the datapath (S = 0)
//   ST_GNT_B | source B owns the datapath (S = 1)
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             S,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             idle
);

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_MAX);

  sel_state_t state_q, state_d;
  logic       last_sel_q, last_sel_d;
  logic       s_q, gnt_a_q, gnt_b_q, idle_q;
  logic       at_max;
  logic       new_grant;

  assign at_max = (hold_cnt == HOLD_TC);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_sel_q == SEL_B) ? ST_GNT_A : ST_GNT_B;
        end else if (req_a) begin
          state_d = ST_GNT_A;
        end else if (req_b) begin
          state_d = ST_GNT_B;
        end
      end
      ST_GNT_A: begin
        if (!req_a || (at_max && req_b)) begin
          state_d = req_b ? ST_GNT_B : ST_IDLE;
        end
      end
      ST_GNT_B: begin
        if (!req_b || (at_max && req_a)) begin
          state_d = req_a ? ST_GNT_A : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A handover counts as a new grant, so the hold counter restarts at 1.
  assign new_grant  = (state_d != ST_IDLE) && (state_d != state_q);
  assign last_sel_d = new_grant ? ((state_d == ST_GNT_B) ? SEL_B : SEL_A) : last_sel_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_sel_q <= SEL_B;
      s_q        <= SEL_A;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
      if (new_grant) begin
        s_q <= last_sel_d;
      end
      gnt_a_q <= (state_d == ST_GNT_A);
      gnt_b_q <= (state_d == ST_GNT_B);
      idle_q  <= (state_d == ST_IDLE);
    end
  end

  sat_counter #(
    .MAX(HOLD_MAX),
    .W  (CNT_W)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_d == ST_IDLE),
    .load1_i(new_grant),
    .en_i   (1'b1),
    .cnt_o  (hold_cnt)
  );

  assign S     = s_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign idle  = idle_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench: drives two arbiters (HOLD_MAX 4 and 1) with shared
// stimulus and compares each cycle against a reference model.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req_a, req_b;

  logic       s0, ga0, gb0, id0;
  logic [2:0] hc0;
  logic       s1, ga1, gb1, id1;
  logic [0:0] hc1;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  // Reference model state per instance: owner 0 none, 1 A, 2 B.
  int   m_own [2];
  int   m_cnt [2];
  logic m_s   [2];
  logic m_last[2];
  int   m_hmax[2];

  always #5 clk = ~clk;

  mux_sel_arbiter #(.HOLD_MAX(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .S(s0), .gnt_a(ga0), .gnt_b(gb0), .hold_cnt(hc0), .idle(id0)
  );

  mux_sel_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .S(s1), .gnt_a(ga1), .gnt_b(gb1), .hold_cnt(hc1), .idle(id1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got S/ga/gb/idle/cnt=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d (t=%0t)",
               tag, obs[7], obs[6], obs[5], obs[4], obs[3:0],
               exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0], $time);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic ra, input logic rb);
    int h;
    h = m_hmax[i];
    if (!rst) begin
      m_own[i] = 0; m_cnt[i] = 0; m_s[i] = 1'b0; m_last[i] = 1'b1;
    end else if (m_own[i] == 0) begin
      if (ra && rb)  m_own[i] = m_last[i] ? 1 : 2;
      else if (ra)   m_own[i] = 1;
      else if (rb)   m_own[i] = 2;
      if (m_own[i] != 0) begin
        m_cnt[i] = 1; m_last[i] = (m_own[i] == 2); m_s[i] = m_last[i];
      end
    end else begin
      logic mine, other;
      mine  = (m_own[i] == 1) ? ra : rb;
      other = (m_own[i] == 1) ? rb : ra;
      if (!mine || (m_cnt[i] == h && other)) begin
        if (other) begin
          m_own[i] = (m_own[i] == 1) ? 2 : 1;
          m_cnt[i] = 1; m_last[i] = (m_own[i] == 2); m_s[i] = m_last[i];
        end else begin
          m_own[i] = 0; m_cnt[i] = 0;
        end
      end else if (m_cnt[i] < h) begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [7:0] model_vec(input int i);
    return {m_s[i], m_own[i] == 1, m_own[i] == 2, m_own[i] == 0, 4'(m_cnt[i])};
  endfunction

  task automatic cycle(input string tag, input logic rst, input logic ra, input logic rb);
    logic [7:0] e0, e1;
    @(negedge clk);
    rst_n = rst; req_a = ra; req_b = rb;
    model_step(0, rst, ra, rb);
    model_step(1, rst, ra, rb);
    exp_q0.push_back(model_vec(0));
    exp_q1.push_back(model_vec(1));
    @(posedge clk);
    #1;
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    chk({tag, "/h4"}, {s0, ga0, gb0, id0, 1'b0, hc0}, e0);
    chk({tag, "/h1"}, {s1, ga1, gb1, id1, 3'b000, hc1}, e1);
  endtask

  initial begin
    m_hmax[0] = 4;
    m_hmax[1] = 1;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;

    repeat (3) cycle("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_const", {s0, ga0, gb0, id0, 1'b0, hc0}, 8'b0001_0000);
    cycle("post_reset", 1'b1, 1'b0, 1'b0);

    repeat (6) cycle("single_a", 1'b1, 1'b1, 1'b0);
    chk("single_sat", {5'b0, hc0}, 8'd4);
    repeat (3) cycle("single_rel", 1'b1, 1'b0, 1'b0);

    // Fresh reset so the tie is resolved by the reset value of last_sel.
    cycle("reset2", 1'b0, 1'b0, 1'b0);
    cycle("tie_first", 1'b1, 1'b1, 1'b1);
    chk("tie_to_a", {s0, ga0, gb0, id0}, 8'b0000_0100);
    repeat (13) cycle("tie_alt", 1'b1, 1'b1, 1'b1);

    repeat (2) cycle("b_hold", 1'b1, 1'b0, 1'b1);
    repeat (2) cycle("late_a", 1'b1, 1'b1, 1'b0);
    repeat (2) cycle("drain", 1'b1, 1'b0, 1'b0);

    repeat (3) cycle("b_to3", 1'b1, 1'b0, 1'b1);
    chk("b_cnt3", {gb0, 4'b0, hc0}, 8'b1000_0011);
    cycle("mid_reset", 1'b0, 1'b0, 1'b1);
    repeat (3) cycle("tie_after_rst", 1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 60; k++) begin
      cycle("random", ($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
